aes_sub_byte: RTL and testbench

- Registered AES SubBytes stage (FIPS-197 §5.1.1) for the 128-bit AES datapath.
- Each of the 16 state bytes is replaced by its forward S-box value.
- The result is captured into an output register when startTransition is asserted.
- It sits between AddRoundKey and ShiftRows in the round pipeline, clocked by the 50 MHz system clock.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_sbox.sv | 84 ++++++++
 rtl/aes_sub_byte.sv | 69 ++++++
 tb/tb_aes_sub_byte.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types and byte-lane helpers.
// Byte 0 sits in the MSBs of the 128-bit state.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    localparam int unsigned AES_NUM_BYTES = 16;

    // Extract byte lane k (0..15).
    function automatic aes_byte_t state_byte(input aes_state_t s, input int unsigned k);
        return s[127 - 8*k -: 8];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one byte in, one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    aes_byte_t sbox_s;

    // Forward S-box table lookup, four entries per line.
    always_comb begin
        case (sbox_in)
            8'h00: sbox_s = 8'h63; 8'h01: sbox_s = 8'h7c; 8'h02: sbox_s = 8'h77; 8'h03: sbox_s = 8'h7b;
            8'h04: sbox_s = 8'hf2; 8'h05: sbox_s = 8'h6b; 8'h06: sbox_s = 8'h6f; 8'h07: sbox_s = 8'hc5;
            8'h08: sbox_s = 8'h30; 8'h09: sbox_s = 8'h01; 8'h0a: sbox_s = 8'h67; 8'h0b: sbox_s = 8'h2b;
            8'h0c: sbox_s = 8'hfe; 8'h0d: sbox_s = 8'hd7; 8'h0e: sbox_s = 8'hab; 8'h0f: sbox_s = 8'h76;
            8'h10: sbox_s = 8'hca; 8'h11: sbox_s = 8'h82; 8'h12: sbox_s = 8'hc9; 8'h13: sbox_s = 8'h7d;
            8'h14: sbox_s = 8'hfa; 8'h15: sbox_s = 8'h59; 8'h16: sbox_s = 8'h47; 8'h17: sbox_s = 8'hf0;
            8'h18: sbox_s = 8'had; 8'h19: sbox_s = 8'hd4; 8'h1a: sbox_s = 8'ha2; 8'h1b: sbox_s = 8'haf;
            8'h1c: sbox_s = 8'h9c; 8'h1d: sbox_s = 8'ha4; 8'h1e: sbox_s = 8'h72; 8'h1f: sbox_s = 8'hc0;
            8'h20: sbox_s = 8'hb7; 8'h21: sbox_s = 8'hfd; 8'h22: sbox_s = 8'h93; 8'h23: sbox_s = 8'h26;
            8'h24: sbox_s = 8'h36; 8'h25: sbox_s = 8'h3f; 8'h26: sbox_s = 8'hf7; 8'h27: sbox_s = 8'hcc;
            8'h28: sbox_s = 8'h34; 8'h29: sbox_s = 8'ha5; 8'h2a: sbox_s = 8'he5; 8'h2b: sbox_s = 8'hf1;
            8'h2c: sbox_s = 8'h71; 8'h2d: sbox_s = 8'hd8; 8'h2e: sbox_s = 8'h31; 8'h2f: sbox_s = 8'h15;
            8'h30: sbox_s = 8'h04; 8'h31: sbox_s = 8'hc7; 8'h32: sbox_s = 8'h23; 8'h33: sbox_s = 8'hc3;
            8'h34: sbox_s = 8'h18; 8'h35: sbox_s = 8'h96; 8'h36: sbox_s = 8'h05; 8'h37: sbox_s = 8'h9a;
            8'h38: sbox_s = 8'h07; 8'h39: sbox_s = 8'h12; 8'h3a: sbox_s = 8'h80; 8'h3b: sbox_s = 8'he2;
            8'h3c: sbox_s = 8'heb; 8'h3d: sbox_s = 8'h27; 8'h3e: sbox_s = 8'hb2; 8'h3f: sbox_s = 8'h75;
            8'h40: sbox_s = 8'h09; 8'h41: sbox_s = 8'h83; 8'h42: sbox_s = 8'h2c; 8'h43: sbox_s = 8'h1a;
            8'h44: sbox_s = 8'h1b; 8'h45: sbox_s = 8'h6e; 8'h46: sbox_s = 8'h5a; 8'h47: sbox_s = 8'ha0;
            8'h48: sbox_s = 8'h52; 8'h49: sbox_s = 8'h3b; 8'h4a: sbox_s = 8'hd6; 8'h4b: sbox_s = 8'hb3;
            8'h4c: sbox_s = 8'h29; 8'h4d: sbox_s = 8'he3; 8'h4e: sbox_s = 8'h2f; 8'h4f: sbox_s = 8'h84;
            8'h50: sbox_s = 8'h53; 8'h51: sbox_s = 8'hd1; 8'h52: sbox_s = 8'h00; 8'h53: sbox_s = 8'hed;
            8'h54: sbox_s = 8'h20; 8'h55: sbox_s = 8'hfc; 8'h56: sbox_s = 8'hb1; 8'h57: sbox_s = 8'h5b;
            8'h58: sbox_s = 8'h6a; 8'h59: sbox_s = 8'hcb; 8'h5a: sbox_s = 8'hbe; 8'h5b: sbox_s = 8'h39;
            8'h5c: sbox_s = 8'h4a; 8'h5d: sbox_s = 8'h4c; 8'h5e: sbox_s = 8'h58; 8'h5f: sbox_s = 8'hcf;
            8'h60: sbox_s = 8'hd0; 8'h61: sbox_s = 8'hef; 8'h62: sbox_s = 8'haa; 8'h63: sbox_s = 8'hfb;
            8'h64: sbox_s = 8'h43; 8'h65: sbox_s = 8'h4d; 8'h66: sbox_s = 8'h33; 8'h67: sbox_s = 8'h85;
            8'h68: sbox_s = 8'h45; 8'h69: sbox_s = 8'hf9; 8'h6a: sbox_s = 8'h02; 8'h6b: sbox_s = 8'h7f;
            8'h6c: sbox_s = 8'h50; 8'h6d: sbox_s = 8'h3c; 8'h6e: sbox_s = 8'h9f; 8'h6f: sbox_s = 8'ha8;
            8'h70: sbox_s = 8'h51; 8'h71: sbox_s = 8'ha3; 8'h72: sbox_s = 8'h40; 8'h73: sbox_s = 8'h8f;
            8'h74: sbox_s = 8'h92; 8'h75: sbox_s = 8'h9d; 8'h76: sbox_s = 8'h38; 8'h77: sbox_s = 8'hf5;
            8'h78: sbox_s = 8'hbc; 8'h79: sbox_s = 8'hb6; 8'h7a: sbox_s = 8'hda; 8'h7b: sbox_s = 8'h21;
            8'h7c: sbox_s = 8'h10; 8'h7d: sbox_s = 8'hff; 8'h7e: sbox_s = 8'hf3; 8'h7f: sbox_s = 8'hd2;
            8'h80: sbox_s = 8'hcd; 8'h81: sbox_s = 8'h0c; 8'h82: sbox_s = 8'h13; 8'h83: sbox_s = 8'hec;
            8'h84: sbox_s = 8'h5f; 8'h85: sbox_s = 8'h97; 8'h86: sbox_s = 8'h44; 8'h87: sbox_s = 8'h17;
            8'h88: sbox_s = 8'hc4; 8'h89: sbox_s = 8'ha7; 8'h8a: sbox_s = 8'h7e; 8'h8b: sbox_s = 8'h3d;
            8'h8c: sbox_s = 8'h64; 8'h8d: sbox_s = 8'h5d; 8'h8e: sbox_s = 8'h19; 8'h8f: sbox_s = 8'h73;
            8'h90: sbox_s = 8'h60; 8'h91: sbox_s = 8'h81; 8'h92: sbox_s = 8'h4f; 8'h93: sbox_s = 8'hdc;
            8'h94: sbox_s = 8'h22; 8'h95: sbox_s = 8'h2a; 8'h96: sbox_s = 8'h90; 8'h97: sbox_s = 8'h88;
            8'h98: sbox_s = 8'h46; 8'h99: sbox_s = 8'hee; 8'h9a: sbox_s = 8'hb8; 8'h9b: sbox_s = 8'h14;
            8'h9c: sbox_s = 8'hde; 8'h9d: sbox_s = 8'h5e; 8'h9e: sbox_s = 8'h0b; 8'h9f: sbox_s = 8'hdb;
            8'ha0: sbox_s = 8'he0; 8'ha1: sbox_s = 8'h32; 8'ha2: sbox_s = 8'h3a; 8'ha3: sbox_s = 8'h0a;
            8'ha4: sbox_s = 8'h49; 8'ha5: sbox_s = 8'h06; 8'ha6: sbox_s = 8'h24; 8'ha7: sbox_s = 8'h5c;
            8'ha8: sbox_s = 8'hc2; 8'ha9: sbox_s = 8'hd3; 8'haa: sbox_s = 8'hac; 8'hab: sbox_s = 8'h62;
            8'hac: sbox_s = 8'h91; 8'had: sbox_s = 8'h95; 8'hae: sbox_s = 8'he4; 8'haf: sbox_s = 8'h79;
            8'hb0: sbox_s = 8'he7; 8'hb1: sbox_s = 8'hc8; 8'hb2: sbox_s = 8'h37; 8'hb3: sbox_s = 8'h6d;
            8'hb4: sbox_s = 8'h8d; 8'hb5: sbox_s = 8'hd5; 8'hb6: sbox_s = 8'h4e; 8'hb7: sbox_s = 8'ha9;
            8'hb8: sbox_s = 8'h6c; 8'hb9: sbox_s = 8'h56; 8'hba: sbox_s = 8'hf4; 8'hbb: sbox_s = 8'hea;
            8'hbc: sbox_s = 8'h65; 8'hbd: sbox_s = 8'h7a; 8'hbe: sbox_s = 8'hae; 8'hbf: sbox_s = 8'h08;
            8'hc0: sbox_s = 8'hba; 8'hc1: sbox_s = 8'h78; 8'hc2: sbox_s = 8'h25; 8'hc3: sbox_s = 8'h2e;
            8'hc4: sbox_s = 8'h1c; 8'hc5: sbox_s = 8'ha6; 8'hc6: sbox_s = 8'hb4; 8'hc7: sbox_s = 8'hc6;
            8'hc8: sbox_s = 8'he8; 8'hc9: sbox_s = 8'hdd; 8'hca: sbox_s = 8'h74; 8'hcb: sbox_s = 8'h1f;
            8'hcc: sbox_s = 8'h4b; 8'hcd: sbox_s = 8'hbd; 8'hce: sbox_s = 8'h8b; 8'hcf: sbox_s = 8'h8a;
            8'hd0: sbox_s = 8'h70; 8'hd1: sbox_s = 8'h3e; 8'hd2: sbox_s = 8'hb5; 8'hd3: sbox_s = 8'h66;
            8'hd4: sbox_s = 8'h48; 8'hd5: sbox_s = 8'h03; 8'hd6: sbox_s = 8'hf6; 8'hd7: sbox_s = 8'h0e;
            8'hd8: sbox_s = 8'h61; 8'hd9: sbox_s = 8'h35; 8'hda: sbox_s = 8'h57; 8'hdb: sbox_s = 8'hb9;
            8'hdc: sbox_s = 8'h86; 8'hdd: sbox_s = 8'hc1; 8'hde: sbox_s = 8'h1d; 8'hdf: sbox_s = 8'h9e;
            8'he0: sbox_s = 8'he1; 8'he1: sbox_s = 8'hf8; 8'he2: sbox_s = 8'h98; 8'he3: sbox_s = 8'h11;
            8'he4: sbox_s = 8'h69; 8'he5: sbox_s = 8'hd9; 8'he6: sbox_s = 8'h8e; 8'he7: sbox_s = 8'h94;
            8'he8: sbox_s = 8'h9b; 8'he9: sbox_s = 8'h1e; 8'hea: sbox_s = 8'h87; 8'heb: sbox_s = 8'he9;
            8'hec: sbox_s = 8'hce; 8'hed: sbox_s = 8'h55; 8'hee: sbox_s = 8'h28; 8'hef: sbox_s = 8'hdf;
            8'hf0: sbox_s = 8'h8c; 8'hf1: sbox_s = 8'ha1; 8'hf2: sbox_s = 8'h89; 8'hf3: sbox_s = 8'h0d;
            8'hf4: sbox_s = 8'hbf; 8'hf5: sbox_s = 8'he6; 8'hf6: sbox_s = 8'h42; 8'hf7: sbox_s = 8'h68;
            8'hf8: sbox_s = 8'h41; 8'hf9: sbox_s = 8'h99; 8'hfa: sbox_s = 8'h2d; 8'hfb: sbox_s = 8'h0f;
            8'hfc: sbox_s = 8'hb0; 8'hfd: sbox_s = 8'h54; 8'hfe: sbox_s = 8'hbb; 8'hff: sbox_s = 8'h16;
            default: sbox_s = 8'h00;
        endcase
    end

    assign sbox_out = sbox_s;

endmodule

// File: rtl/aes_sub_byte.sv
// Registered AES SubBytes stage: 16 parallel S-boxes feeding a 128-bit enable register.
// Optional registered capture flag subByteDone under macro AES_SUB_BYTE_DONE_EN.
module aes_sub_byte
    import aes_pkg::*;
(
    input  logic         clock50MHz,
    input  logic         reset_n,
    input  logic         startTransition,
    input  logic [127:0] subByteInput,
    output logic [127:0] subByteOutput
`ifdef AES_SUB_BYTE_DONE_EN
    ,
    output logic         subByteDone
`endif
);

    aes_state_t sub_s;
    aes_state_t sub_byte_d;
    aes_state_t sub_byte_q;

    for (genvar k = 0; k < AES_NUM_BYTES; k++) begin : g_lane
        aes_sbox u_sbox (
            .sbox_in  (state_byte(subByteInput, k)),
            .sbox_out (sub_s[127 - 8*k -: 8])
        );
    end

    // Capture the substituted state on enable, otherwise hold.
    always_comb begin
        if (startTransition) begin
            sub_byte_d = sub_s;
        end else begin
            sub_byte_d = sub_byte_q;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clock50MHz or negedge reset_n) begin
        if (!reset_n) begin
            sub_byte_q <= 128'h0;
        end else begin
            sub_byte_q <= sub_byte_d;
        end
    end

    assign subByteOutput = sub_byte_q;

`ifdef AES_SUB_BYTE_DONE_EN
    logic done_d;
    logic done_q;

    // Done follows the enable one cycle late, marking a fresh capture.
    always_comb begin
        done_d = startTransition;
    end

    // Done flag register with asynchronous clear.
    always_ff @(posedge clock50MHz or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign subByteDone = done_q;
`endif

endmodule

// File: tb/tb_aes_sub_byte.sv
// Directed bench for aes_sub_byte: reset, capture, hold, async reset and per-lane S-box sweep.
module tb_aes_sub_byte;

    logic         clock50MHz;
    logic         reset_n;
    logic         startTransition;
    logic [127:0] subByteInput;
    logic [127:0] subByteOutput;
`ifdef AES_SUB_BYTE_DONE_EN
    logic         subByteDone;
`endif

    int total;
    int bad;

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [2047:0] sbox_vec;
    logic [7:0]    sbox_tbl [256];

    aes_sub_byte dut (
        .clock50MHz      (clock50MHz),
        .reset_n         (reset_n),
        .startTransition (startTransition),
        .subByteInput    (subByteInput),
        .subByteOutput   (subByteOutput)
`ifdef AES_SUB_BYTE_DONE_EN
        ,
        .subByteDone     (subByteDone)
`endif
    );

    initial clock50MHz = 1'b0;
    always #10 clock50MHz = ~clock50MHz;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock50MHz);
        #1;
    endtask

    initial begin
        logic [127:0] exp_v;
        total = 0;
        bad   = 0;
        sbox_vec = SBOX_HEX;
        for (int i = 0; i < 256; i++) sbox_tbl[i] = sbox_vec[2047 - 8*i -: 8];

        // Reset, then idle with enable low.
        reset_n         = 1'b0;
        startTransition = 1'b0;
        subByteInput    = 128'h00102030405060708090a0b0c0d0e0f0;
        step();
        step();
        check_eq("reset_out", subByteOutput, 128'h0);
`ifdef AES_SUB_BYTE_DONE_EN
        check_eq("reset_done", {127'h0, subByteDone}, 128'h0);
`endif
        reset_n = 1'b1;
        for (int c = 1; c <= 500; c++) begin
            step();
            if (c % 100 == 0) check_eq("idle_out", subByteOutput, 128'h0);
        end

        // Capture the column-head vector and confirm it stays stable.
        startTransition = 1'b1;
        step();
        check_eq("vec_capture", subByteOutput, 128'h63cab7040953d051cd60e0e7ba70e18c);
`ifdef AES_SUB_BYTE_DONE_EN
        check_eq("done_capture", {127'h0, subByteDone}, 128'h1);
`endif
        step();
        step();
        check_eq("vec_stable", subByteOutput, 128'h63cab7040953d051cd60e0e7ba70e18c);

        subByteInput = 128'h0;
        step();
        check_eq("all_zero", subByteOutput, 128'h63636363636363636363636363636363);
        subByteInput = {128{1'b1}};
        step();
        check_eq("all_ff", subByteOutput, 128'h16161616161616161616161616161616);

        // Hold behaviour.
        subByteInput = 128'h53535353535353535353535353535353;
        step();
        check_eq("cap_53", subByteOutput, 128'hedededededededededededededededed);
        startTransition = 1'b0;
        subByteInput    = 128'h01010101010101010101010101010101;
        step();
        check_eq("hold_1", subByteOutput, 128'hedededededededededededededededed);
`ifdef AES_SUB_BYTE_DONE_EN
        check_eq("done_hold", {127'h0, subByteDone}, 128'h0);
`endif
        step();
        check_eq("hold_2", subByteOutput, 128'hedededededededededededededededed);
        startTransition = 1'b1;
        step();
        check_eq("recap_01", subByteOutput, 128'h7c7c7c7c7c7c7c7c7c7c7c7c7c7c7c7c);

        // Asynchronous reset between edges while enabled.
        subByteInput = 128'h10101010101010101010101010101010;
        step();
        check_eq("cap_10", subByteOutput, 128'hcacacacacacacacacacacacacacacaca);
        #5;
        reset_n = 1'b0;
        #1;
        check_eq("async_clr", subByteOutput, 128'h0);
`ifdef AES_SUB_BYTE_DONE_EN
        check_eq("async_done", {127'h0, subByteDone}, 128'h0);
`endif
        step();
        check_eq("rst_hold", subByteOutput, 128'h0);
        #5;
        reset_n = 1'b1;
        step();
        check_eq("post_rst", subByteOutput, 128'hcacacacacacacacacacacacacacacaca);
`ifdef AES_SUB_BYTE_DONE_EN
        check_eq("post_rst_done", {127'h0, subByteDone}, 128'h1);
`endif

        // Per-lane sweep against the reference table.
        for (int lane = 0; lane < 16; lane++) begin
            for (int v = 0; v < 256; v++) begin
                subByteInput = 128'h0;
                subByteInput[127 - 8*lane -: 8] = v[7:0];
                step();
                exp_v = 128'h63636363636363636363636363636363;
                exp_v[127 - 8*lane -: 8] = sbox_tbl[v];
                check_eq($sformatf("sweep_l%0d_v%02h", lane, v), subByteOutput, exp_v);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
